// File: rtl/seven_seg_scanner_if.sv
// Bundle between the data source and the 7-segment scanner.
// The master supplies nibbles and controls. The slave drives the display pins.
interface seven_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  iEnable;
  logic [4*DIGITS-1:0]   ivData;
  logic [DIGITS-1:0]     ivDp;
  logic [DIGITS-1:0]     ivBlank;
  logic                  iLzb;
  logic [2:0]            ivBright;
  logic [DIGITS-1:0]     ovAnode;
  logic [6:0]            ovSeg;
  logic                  oDp;
  logic                  oFrame;

  modport master (
    output iEnable, ivData, ivDp, ivBlank, iLzb, ivBright,
    input  ovAnode, ovSeg, oDp, oFrame
  );

  modport slave (
    input  iEnable, ivData, ivDp, ivBlank, iLzb, ivBright,
    output ovAnode, ovSeg, oDp, oFrame
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with prescaler, hex decode,
// leading-zero blanking, per-digit blanking/DP and 8-level brightness.
module seven_seg_scanner #(
  parameter int DIGITS           = 4,
  parameter int CLK_DIV          = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic               iClk,
  input  logic               iReset,
  seven_seg_scanner_if.slave bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W = $clog2(DIGITS);

  logic [PRE_W-1:0]      pre;
  logic [2:0]            phase;
  logic [DIG_W-1:0]      digit;
  logic [4*DIGITS-1:0]   shadow_data;
  logic [DIGITS-1:0]     shadow_dp;
  logic [DIGITS-1:0]     shadow_blank;

  logic [DIGITS-1:0]     anode_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic                  frame_reg;

  logic                  tick;
  logic                  load;
  logic                  wrap;
  logic [4*DIGITS-1:0]   cur_data;
  logic [DIGITS-1:0]     cur_dp;
  logic [DIGITS-1:0]     cur_blank;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     lz_mask;
  logic                  zero_above;
  logic                  dark;
  logic                  anode_on;
  logic [6:0]            decoded;
  logic [DIGITS-1:0]     anode_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  assign tick = (pre == PRE_W'(CLK_DIV - 1));
  assign load = bus.iEnable && (digit == '0) && (phase == 3'd0) && (pre == '0);
  assign wrap = bus.iEnable && tick && (phase == 3'd7) && (digit == DIG_W'(DIGITS - 1));

  // The load cycle already displays the freshly captured inputs, so the
  // whole frame (including its first cycle) shows one consistent snapshot.
  assign cur_data  = load ? bus.ivData  : shadow_data;
  assign cur_dp    = load ? bus.ivDp    : shadow_dp;
  assign cur_blank = load ? bus.ivBlank : shadow_blank;
  assign nibble    = cur_data[4*int'(digit) +: 4];

  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (cur_data[4*i +: 4] == 4'd0);
      lz_mask[i] = (i != 0) && zero_above;
    end
  end

  assign dark     = cur_blank[digit] || (bus.iLzb && lz_mask[digit]);
  assign anode_on = bus.iEnable && !dark && (phase <= bus.ivBright);

  always_comb begin
    decoded = 7'b0000000;
    case (nibble)
      4'h0: decoded = 7'b0111111;
      4'h1: decoded = 7'b0000110;
      4'h2: decoded = 7'b1011011;
      4'h3: decoded = 7'b1001111;
      4'h4: decoded = 7'b1100110;
      4'h5: decoded = 7'b1101101;
      4'h6: decoded = 7'b1111101;
      4'h7: decoded = 7'b0000111;
      4'h8: decoded = 7'b1111111;
      4'h9: decoded = 7'b1101111;
      4'hA: decoded = 7'b1110111;
      4'hB: decoded = 7'b1111100;
      4'hC: decoded = 7'b0111001;
      4'hD: decoded = 7'b1011110;
      4'hE: decoded = 7'b1111001;
      4'hF: decoded = 7'b1110001;
      default: decoded = 7'b0000000;
    endcase
  end

  assign anode_hi = anode_on ? (DIGITS'(1) << digit) : '0;
  assign seg_hi   = anode_on ? decoded : 7'b0000000;
  assign dp_hi    = anode_on && cur_dp[digit];

  // Counters hold while disabled; the output stage goes dark in the same edge.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pre          <= '0;
      phase        <= 3'd0;
      digit        <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      anode_reg    <= ANODE_ACTIVE_LOW ? '1 : '0;
      seg_reg      <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_reg       <= SEG_ACTIVE_LOW;
      frame_reg    <= 1'b0;
    end else begin
      if (load) begin
        shadow_data  <= bus.ivData;
        shadow_dp    <= bus.ivDp;
        shadow_blank <= bus.ivBlank;
      end
      if (bus.iEnable) begin
        if (tick) begin
          pre   <= '0;
          phase <= phase + 3'd1;
          if (phase == 3'd7) begin
            digit <= (digit == DIG_W'(DIGITS - 1)) ? '0 : digit + DIG_W'(1);
          end
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
      anode_reg <= ANODE_ACTIVE_LOW ? ~anode_hi : anode_hi;
      seg_reg   <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_reg    <= SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
      frame_reg <= wrap;
    end
  end

  assign bus.ovAnode = anode_reg;
  assign bus.ovSeg   = seg_reg;
  assign bus.oDp     = dp_reg;
  assign bus.oFrame  = frame_reg;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display. It replaces the fixed 4-digit anode rotator and adds:
- an internal refresh prescaler;
- hex-to-segment decode;
- per-digit decimal points and blanking;
- leading-zero suppression;
- 8-level brightness control by duty cycle within each digit slot.

It sits between the UART/data datapath, which supplies packed nibbles, and the board's anode/segment pins.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned; legal range 2..8.
- CLK_DIV, 50000, iClk cycles per brightness phase; legal range ≥1.
- ANODE_ACTIVE_LOW, 1, when 1 ovAnode is inverted at the pin (active level 0).
- SEG_ACTIVE_LOW, 1, when 1 ovSeg and oDp are inverted at the pin (lit level 0).

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  scan enable; when low, counters hold and the display is dark.
- ivData  in  4*DIGITS  packed hex nibbles; nibble i, bits [4i+3:4i], drives digit i; digit 0 is least significant.
- ivDp  in  DIGITS  decimal-point request per digit.
- ivBlank  in  DIGITS  force digit i dark.
- iLzb  in  1  leading-zero blanking enable.
- ivBright  in  3  brightness; the anode is on for (ivBright+1)/8 of each digit slot.
- ovAnode  out  DIGITS  one-hot digit select, or all inactive.
- ovSeg  out  7  segments {g,f,e,d,c,b,a}.
- oDp  out  1  decimal point.
- oFrame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- State registers:
  - rPre (0..CLK_DIV-1)
  - rPhase (0..7)
  - rDigit (0..DIGITS-1)
  - rShadowData, rShadowDp, rShadowBlank
- Prescaler: while iEnable, rPre increments. A tick occurs in the cycle where rPre==CLK_DIV-1; rPre then returns to 0. With CLK_DIV=1, every enabled cycle is a tick.
- On a tick, rPhase increments. On a tick with rPhase==7:
  - rPhase becomes 0;
  - rDigit advances, wrapping from DIGITS-1 to 0;
  - oFrame pulses if the advance is a wrap.
- One digit slot = 8*CLK_DIV cycles. One frame = DIGITS*8*CLK_DIV cycles.
- Shadow load: the shadow registers capture ivData, ivDp and ivBlank in every enabled cycle where rDigit==0, rPhase==0 and rPre==0. This is the first cycle of each frame, including the first enabled cycle after reset. Input changes mid-frame must not alter the current frame. ivBright and iLzb are not shadowed.
- Leading-zero blanking: with iLzb=1, digit i (i≥1) is blanked if every shadow nibble from DIGITS-1 down to i is 0. Digit 0 is never LZ-blanked, so value 0 shows a single "0".
- Digit i is dark if rShadowBlank[i]=1 or it is LZ-blanked. A dark digit has all anodes inactive and all segments and oDp unlit for the whole slot.
- Anode on condition: iEnable=1, the digit is not dark, and rPhase ≤ ivBright.
- Decode, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- oDp = rShadowDp[rDigit] when the anode is on.
- Whenever the anode is off, ovSeg and oDp are unlit. This prevents ghosting.
- iEnable low: rPre, rPhase and rDigit hold, no shadow load occurs, and the outputs go fully inactive.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect state and inputs sampled in cycle n (latency 1).
- Reset (synchronous): rPre=0, rPhase=0, rDigit=0, shadows=0. Outputs take these values at the next edge:
  - ovAnode all inactive (all 1s when ANODE_ACTIVE_LOW=1);
  - ovSeg and oDp unlit (all 1s when SEG_ACTIVE_LOW=1);
  - oFrame=0.
- Reset mid-scan: takes effect at the next edge, whatever the state. The scan restarts at digit 0, phase 0. The first enabled cycle after reset loads the shadow.
- oFrame is asserted in the cycle after the wrapping tick, coincident with the first output cycle of digit 0. It is high for exactly 1 cycle.
- A change of ivBright takes effect within 1 cycle; no glitch longer than 1 cycle is permitted.
- Simultaneous iReset and iEnable: reset wins.

## Test plan
- Reset: assert iReset 2 cycles with DIGITS=4 and active-low outputs -> ovAnode=4'b1111, ovSeg=7'h7F, oDp=1 and oFrame=0 at the next edge.
- Scan order: CLK_DIV=2, ivBright=7, ivData=16'h1234 -> each digit is active for 16 cycles in order 0,1,2,3. Segment patterns are 4,3,2,1 decoded. oFrame pulses every 64 cycles.
- Brightness: CLK_DIV=2, ivBright=1 -> the anode is active for 4 of 16 cycles per slot. ivBright=0 -> 2 of 16.
- Leading zeros: ivData=16'h0042, iLzb=1 -> digits 3 and 2 are dark, digits 1 and 0 show 4 and 2. ivData=0 -> only digit 0 lit, showing "0".
- Tearing: change ivData from 16'h1111 to 16'h2222 mid-frame -> the current frame shows all 1s; the next frame shows all 2s. ivBlank=4'b0100 -> digit 2 is never lit.
- Enable and reset mid-operation: drop iEnable at digit 2 for 10 cycles -> outputs are inactive and the counters hold; the scan resumes at the same digit and phase. Assert iReset at digit 3 -> the scan restarts at digit 0 with the shadow reloaded.
